// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target model.
// Pure declarations; no logic, no latency.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK
  } state_e;

  localparam logic [6:0] DEF_I2C_ADDR = 7'h10;
  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer plus one history flop; level/rise/fall appear 2 PCLK after the pin moves.
// No flow control: one-cycle edge pulses, resets to the idle-high bus level.
module i2c_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~hist_q;
  assign fall_o  = ~sync_q & hist_q;

endmodule

// File: rtl/i2c_slave_model.sv
// I2C target with a small auto-incrementing byte register file; sda drive updates one PCLK after a synced SCL fall.
// No clock stretching: the target never holds scl, it only ACKs its own address and drives read data.
module i2c_slave_model
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = DEF_I2C_ADDR,
  parameter int         MEM_AW   = 2
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic scl,
  inout  wire  sda
);

  localparam int DEPTH = 1 << MEM_AW;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl_sync (
    .clk_i  (PCLK),
    .rst_ni (PRESETn),
    .d_i    (scl),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk_i  (PCLK),
    .rst_ni (PRESETn),
    .d_i    (sda),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        sr_q, sr_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic              oe_q, oe_d;
  logic              rw_q, rw_d;
  logic              mem_we;
  logic [7:0]        mem_q [DEPTH];

  logic              start_det, stop_det;
  logic [7:0]        rx_byte;
  logic [MEM_AW-1:0] ptr_inc;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign rx_byte   = {sr_q[6:0], sda_lvl};
  assign ptr_inc   = ptr_q + MEM_AW'(1);

  assign sda = oe_q ? 1'b0 : 1'bz;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    ptr_d   = ptr_q;
    oe_d    = oe_q;
    rw_d    = rw_q;
    mem_we  = 1'b0;

    if (start_det) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR, REG, WDATA: begin
          if (scl_rise) begin
            sr_d  = rx_byte;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              case (state_q)
                ADDR: begin
                  if (rx_byte[7:1] == I2C_ADDR) begin
                    rw_d    = rx_byte[0];
                    state_d = ADDR_ACK;
                  end else begin
                    state_d = IDLE;
                  end
                end
                REG: begin
                  ptr_d   = rx_byte[MEM_AW-1:0];
                  state_d = REG_ACK;
                end
                default: begin
                  mem_we  = 1'b1;
                  ptr_d   = ptr_inc;
                  state_d = WDATA_ACK;
                end
              endcase
            end
          end
        end
        // cnt 0: the fall ending bit 8 starts the ACK; cnt 1: the fall ending the 9th clock ends it.
        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              oe_d  = 1'b1;
              cnt_d = 4'd1;
            end else begin
              cnt_d = 4'd0;
              oe_d  = 1'b0;
              if (state_q == ADDR_ACK && rw_q) begin
                sr_d    = mem_q[ptr_q];
                oe_d    = ~mem_q[ptr_q][7];
                state_d = RDATA;
              end else if (state_q == ADDR_ACK) begin
                state_d = REG;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d = RACK;
              oe_d    = 1'b0;
              cnt_d   = 4'd0;
            end else begin
              sr_d = {sr_q[6:0], 1'b0};
              oe_d = ~sr_q[6];
            end
          end
        end
        // Next byte is loaded at the ACK sample but only driven after scl falls again.
        RACK: begin
          if (scl_rise) begin
            ptr_d = ptr_inc;
            if (sda_lvl == ACK) begin
              sr_d = mem_q[ptr_inc];
            end else begin
              state_d = IDLE;
            end
          end else if (scl_fall) begin
            state_d = RDATA;
            oe_d    = ~sr_q[7];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sr_q    <= 8'h00;
      ptr_q   <= '0;
      oe_q    <= 1'b0;
      rw_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      ptr_q   <= ptr_d;
      oe_q    <= oe_d;
      rw_q    <= rw_d;
      if (mem_we) begin
        mem_q[ptr_q] <= rx_byte;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_model.sv
// Directed bench for the I2C target: bit-banged master on an open-drain bus with pull-up.
// Each comparison is an immediate assertion against a hand-computed value.
module tb_i2c_slave_model;

  logic PCLK      = 1'b0;
  logic PRESETn   = 1'b0;
  logic scl       = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda_bus;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] rd_buf [4];

  i2c_slave_model #(.I2C_ADDR(7'h10), .MEM_AW(2)) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .scl    (scl),
    .sda    (sda_bus)
  );

  always #5 PCLK = ~PCLK;

  task automatic cyc(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All bit tasks start with scl just driven low (or idle high for start).
  task automatic send_bit(input logic b);
    cyc(5); m_sda_low = ~b; cyc(5); scl = 1'b1; cyc(10); scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    cyc(5); m_sda_low = 1'b0; cyc(5); scl = 1'b1; cyc(5); b = sda_bus; cyc(5); scl = 1'b0;
  endtask

  task automatic i2c_start();
    cyc(5); m_sda_low = 1'b0; cyc(5); scl = 1'b1; cyc(10); m_sda_low = 1'b1; cyc(10); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    cyc(5); m_sda_low = 1'b1; cyc(5); scl = 1'b1; cyc(10); m_sda_low = 1'b0; cyc(10);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic mack);
    logic [7:0] tmp;
    for (int i = 7; i >= 0; i--) recv_bit(tmp[i]);
    d = tmp;
    send_bit(~mack);
  endtask

  task automatic tx(input string tag, input logic [7:0] b, input logic exp_ack);
    logic a;
    send_byte(b, a);
    check(tag, {7'b0, a}, {7'b0, exp_ack});
  endtask

  task automatic read_seq(input logic [7:0] ptr, input int n);
    logic [7:0] d;
    i2c_start();
    tx("rd_addr_w", 8'h20, 1'b0);
    tx("rd_ptr", ptr, 1'b0);
    i2c_start();
    tx("rd_addr_r", 8'h21, 1'b0);
    for (int i = 0; i < n; i++) begin
      recv_byte(d, i != n - 1);
      rd_buf[i] = d;
    end
    i2c_stop();
  endtask

  initial begin
    logic a;

    // Reset with bus idle
    cyc(10);
    check("rst_sda_released", {7'b0, sda_bus}, 8'h01);
    PRESETn = 1'b1;
    cyc(10);
    read_seq(8'h00, 4);
    check("rst_mem0", rd_buf[0], 8'h00);
    check("rst_mem1", rd_buf[1], 8'h00);
    check("rst_mem2", rd_buf[2], 8'h00);
    check("rst_mem3", rd_buf[3], 8'h00);

    // Write two bytes starting at pointer 1
    i2c_start();
    tx("wr_addr", 8'h20, 1'b0);
    tx("wr_ptr", 8'h01, 1'b0);
    tx("wr_d0", 8'hA5, 1'b0);
    tx("wr_d1", 8'h3C, 1'b0);
    i2c_stop();

    // Read back with repeated START, ACK then NACK
    read_seq(8'h01, 2);
    check("rd_byte0", rd_buf[0], 8'hA5);
    check("rd_byte1", rd_buf[1], 8'h3C);

    // Foreign address: no ACK, target stays quiet
    i2c_start();
    tx("bad_addr_nack", 8'h40, 1'b1);
    tx("bad_data_nack", 8'h00, 1'b1);
    i2c_stop();
    read_seq(8'h00, 4);
    check("bad_mem0", rd_buf[0], 8'h00);
    check("bad_mem1", rd_buf[1], 8'hA5);
    check("bad_mem2", rd_buf[2], 8'h3C);
    check("bad_mem3", rd_buf[3], 8'h00);

    // Pointer wraps 3 -> 0 on writes, and on reads
    i2c_start();
    tx("wrap_addr", 8'h20, 1'b0);
    tx("wrap_ptr", 8'h03, 1'b0);
    tx("wrap_d0", 8'h11, 1'b0);
    tx("wrap_d1", 8'h22, 1'b0);
    i2c_stop();
    read_seq(8'h00, 4);
    check("wrap_mem0", rd_buf[0], 8'h22);
    check("wrap_mem1", rd_buf[1], 8'hA5);
    check("wrap_mem2", rd_buf[2], 8'h3C);
    check("wrap_mem3", rd_buf[3], 8'h11);
    read_seq(8'h07, 2);
    check("wrap_rd3", rd_buf[0], 8'h11);
    check("wrap_rd0", rd_buf[1], 8'h22);

    // Reset while the target is driving its address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(8'h20 >> i);
    cyc(5);
    m_sda_low = 1'b0;
    check("ack_driven_low", {7'b0, sda_bus}, 8'h00);
    PRESETn = 1'b0;
    #1;
    check("async_rst_release", {7'b0, sda_bus}, 8'h01);
    cyc(3);
    scl = 1'b1;
    cyc(5);
    PRESETn = 1'b1;
    cyc(10);
    read_seq(8'h00, 4);
    check("post_rst_mem0", rd_buf[0], 8'h00);
    check("post_rst_mem1", rd_buf[1], 8'h00);
    check("post_rst_mem2", rd_buf[2], 8'h00);
    check("post_rst_mem3", rd_buf[3], 8'h00);

    // Reset while the target is driving a 0 read-data bit
    i2c_start();
    tx("rdrst_addr", 8'h21, 1'b0);
    recv_bit(a);
    check("rdata_bit7", {7'b0, a}, 8'h00);
    cyc(8);
    check("rdata_driven_low", {7'b0, sda_bus}, 8'h00);
    PRESETn = 1'b0;
    #1;
    check("rdata_async_release", {7'b0, sda_bus}, 8'h01);
    cyc(3);
    scl = 1'b1;
    cyc(5);
    PRESETn = 1'b1;
    cyc(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_slave_model.md
Name: i2c_slave_model

Overview:
- Synthesizable I2C target (slave) that sits on the same scl/sda bus as the APB-to-I2C master (top_level) in the system-level bench.
- Oversamples scl/sda on PCLK, decodes START/STOP/address/data, and ACKs its own 7-bit address.
- Serves reads and writes to a small internal byte register file with an auto-incrementing pointer.

Parameters:
- I2C_ADDR, 7'h10, 7-bit target address this block responds to.
- MEM_AW, 2, register-file address width; depth = 2**MEM_AW bytes (default 4).

Ports:
- PCLK  input  1  system clock; all logic on rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- scl  input  1  I2C clock from the master (bus pulled up externally).
- sda  inout  1  I2C data, open-drain.
  - Driven 1'b0 when the target pulls low; otherwise 1'bz. Never driven 1.

Behaviour:
- Reset (PRESETn=0, async):
  - state=IDLE, sda released (z).
  - All memory bytes = 8'h00, pointer = 0, bit counter = 0, shift register = 0.
- Input conditioning:
  - scl and sda each pass through a 2-flop synchronizer, then a 1-cycle history register for edge detection.
  - Required bus timing: scl high and low phases each ≥4 PCLK.
- Event detection (synced signals):
  - START = sda falls while scl high.
  - STOP = sda rises while scl high.
  - SCL_RISE / SCL_FALL = edges of synced scl.
- Bit timing:
  - Sample sda on SCL_RISE.
  - Update the target's sda drive on the PCLK following SCL_FALL.
  - Bits are MSB first.
- START from any state (including repeated START):
  - Go to ADDR, clear bit counter, release sda.
  - Pointer is preserved.
- STOP from any state: go to IDLE, release sda.
- States:
  - IDLE: ignore everything except START.
  - ADDR: shift 8 bits (7 address + R/W).
    - Address == I2C_ADDR: go to ADDR_ACK.
    - Otherwise: go to IDLE without ACK.
  - ADDR_ACK: drive sda=0 for the 9th clock, release on the following SCL_FALL.
    - R/W=0: go to REG.
    - R/W=1: load mem[pointer] into the shift register and go to RDATA.
  - REG: shift 8 bits.
    - pointer <= byte[MEM_AW-1:0]; upper bits ignored.
    - ACK, then go to WDATA.
  - WDATA: shift 8 bits.
    - On the 8th SCL_RISE: mem[pointer] <= byte and pointer increments.
    - ACK, then stay in WDATA for the next byte.
  - RDATA: drive sda=0 for each 0 bit, release for each 1 bit (8 bits); go to RACK.
  - RACK: release sda and sample master's ACK on SCL_RISE.
    - Master ACK (0): pointer increments, load next byte, go to RDATA.
    - Master NACK (1): pointer increments, go to IDLE and wait for STOP/START.
- Pointer increment wraps modulo 2**MEM_AW (3 -> 0 at default).
- Simultaneous START/STOP detection with SCL edge: START/STOP take priority.
- Reset asserted mid-transfer: sda released immediately (asynchronously); all state is lost.

Decomposition:
- Package i2c_pkg holds:
  - state enum {IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RACK}.
  - Default I2C_ADDR constant.
  - ACK/NACK bit constants.
- One sub-module, i2c_sync_edge: 2-flop synchronizer plus rise/fall detector.
  - Instantiated for scl and for sda.
  - Outputs level, rise, fall.

Test Plan:
- Reset: hold PRESETn=0 with bus idle, then release -> sda=z, all mem reads return 8'h00.
- Write: START, 8'h20 (addr 0x10, W), 8'h01, 8'hA5, 8'h3C, STOP.
  - Required: ACK on all 4 bytes.
  - Required: mem[1]=8'hA5, mem[2]=8'h3C.
- Read with repeated START: START, 8'h20, 8'h01, rSTART, 8'h21, read 2 bytes (master ACK, then NACK), STOP.
  - Required: target returns 8'hA5 then 8'h3C.
- Wrong address: START, 8'h40, ... -> 9th clock sees sda=1 (NACK); no memory change; target stays released until the next START.
- Wrap-around: write pointer 8'h03, then data 8'h11, 8'h22 -> mem[3]=8'h11, mem[0]=8'h22.
- Mid-transfer reset: assert PRESETn=0 during target ACK/read-data drive -> sda=z immediately; after release, a fresh transaction works and mem reads back 8'h00.
